// File: rtl/read_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : read_engine_pkg
//  Description : Shared types and constants for the AFU host read-request
//                engine: parent AFU state encoding, request metadata tags,
//                the start-run control code and the control-line layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package read_engine_pkg;

    localparam int C_ADDR_W  = 42;
    localparam int C_MDATA_W = 16;
    localparam int C_CNT_W   = 32;
    localparam int C_CODE_W  = 32;

    // Parent AFU state as presented on the afu_state port
    typedef enum logic [1:0] {
        AFU_IDLE = 2'd0,
        AFU_CTRL = 2'd1,
        AFU_RUN  = 2'd2,
        AFU_DONE = 2'd3
    } afu_state_e;

    // Metadata tags that let the response path tell control from data lines
    localparam logic [C_MDATA_W-1:0] C_CTRL_MDATA     = 16'h0001;
    localparam logic [C_MDATA_W-1:0] C_RUN_MDATA      = 16'h0002;
    localparam logic [C_CODE_W-1:0]  C_START_RUN_CODE = 32'h0000_0001;

    // Control cache-line contents as decoded by the parent
    typedef struct packed {
        logic [C_CODE_W-1:0] code;
        logic [C_ADDR_W-1:0] rd_addr;
        logic [C_ADDR_W-1:0] wr_addr;
        logic [C_CNT_W-1:0]  num_cls;
    } ctrl_resp_t;

endpackage
`default_nettype wire

// File: rtl/read_engine_rd_line_counter.sv
`default_nettype none
// ============================================================================
//  Module      : rd_line_counter
//  Description : Data-phase bookkeeping for the read engine. Holds the base
//                line address and line count of the current run, counts the
//                data requests issued and produces the address of the next
//                line plus a "lines remaining" flag.
//  Ports       : clk, reset_n          - clock, async active-low reset
//                load, load_base/num   - start a new run (clears issued)
//                inc                   - one data request issued this cycle
//                issued                - data requests issued so far
//                line_addr             - base + issued (mod 2^ADDR_W)
//                remaining             - issued < num
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_line_counter #(
    parameter int ADDR_W = 42,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [CNT_W-1:0]  load_num,
    input  logic              inc,
    output logic [CNT_W-1:0]  issued,
    output logic [ADDR_W-1:0] line_addr,
    output logic              remaining
);

    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_issued;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base   <= '0;
            r_num    <= '0;
            r_issued <= '0;
        end else if (load) begin
            r_base   <= load_base;
            r_num    <= load_num;
            r_issued <= '0;
        end else if (inc) begin
            r_issued <= r_issued + 1'b1;
        end
    end

    // Address wraps silently at 2^ADDR_W by truncation
    assign line_addr = r_base + ADDR_W'(r_issued);
    assign remaining = (r_issued < r_num);
    assign issued    = r_issued;

endmodule
`default_nettype wire

// File: rtl/read_engine.sv
`default_nettype none
// ============================================================================
//  Module      : read_engine
//  Description : Read-request generator for the AFU host read channel.
//                Fetches the control cache line, re-polls until the response
//                carries the start-run code, then streams sequential single-
//                line data reads over the described region. All outputs are
//                registered; a request appears the cycle after it is issued.
//  Ports       : clk, reset_n          - clock, async active-low reset
//                stall                 - suppress request issue this cycle
//                afu_state             - parent state (IDLE/CTRL/RUN/DONE)
//                ctrl_addr             - control-block line address
//                ctrl_resp_*           - decoded control line (valid pulse)
//                rd_valid/mdata/addr   - request to the c0 header builder
//                rd_done               - all data requests issued
//                rd_issued             - data requests issued so far
//                stall_cycles          - stall statistics counter
//  Config      : READ_ENGINE_STATS_EN  - enables the stall_cycles counter;
//                                        otherwise stall_cycles is tied to 0
//  Revision    : 1.0 - initial release
// ============================================================================
module read_engine
    import read_engine_pkg::*;
#(
    parameter int                  ADDR_W         = C_ADDR_W,
    parameter int                  MDATA_W        = C_MDATA_W,
    parameter int                  CNT_W          = C_CNT_W,
    parameter logic [MDATA_W-1:0]  CTRL_MDATA     = MDATA_W'(C_CTRL_MDATA),
    parameter logic [MDATA_W-1:0]  RUN_MDATA      = MDATA_W'(C_RUN_MDATA),
    parameter logic [31:0]         START_RUN_CODE = C_START_RUN_CODE
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic [1:0]         afu_state,
    input  logic [ADDR_W-1:0]  ctrl_addr,
    input  logic               ctrl_resp_valid,
    input  logic [31:0]        ctrl_resp_code,
    input  logic [ADDR_W-1:0]  ctrl_resp_rd_addr,
    input  logic [CNT_W-1:0]   ctrl_resp_num_cls,
    output logic               rd_valid,
    output logic [MDATA_W-1:0] rd_mdata,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_done,
    output logic [CNT_W-1:0]   rd_issued,
    output logic [CNT_W-1:0]   stall_cycles
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CTRL_REQ  = 3'd1;
    localparam logic [2:0] S_CTRL_WAIT = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;

    afu_state_e         w_afu;
    logic               w_abort;
    logic               w_resp_start;

    logic               w_ctrl_issue;
    logic               w_run_issue;
    logic               w_load;
    logic               w_valid_next;
    logic [MDATA_W-1:0] w_mdata_next;
    logic [ADDR_W-1:0]  w_addr_next;

    logic [ADDR_W-1:0]  w_line_addr;
    logic               w_remaining;

    logic               r_rd_valid;
    logic [MDATA_W-1:0] r_rd_mdata;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_rd_done;

    assign w_afu        = afu_state_e'(afu_state);
    // Parent returning to IDLE overrides every other condition
    assign w_abort      = (w_afu == AFU_IDLE);
    assign w_resp_start = ctrl_resp_valid && (ctrl_resp_code == START_RUN_CODE);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_afu == AFU_CTRL) w_state_next = S_CTRL_REQ;
                end
                S_CTRL_REQ: begin
                    if (!stall) w_state_next = S_CTRL_WAIT;
                end
                S_CTRL_WAIT: begin
                    if (ctrl_resp_valid) begin
                        if (!w_resp_start)                w_state_next = S_CTRL_REQ;
                        else if (ctrl_resp_num_cls == '0) w_state_next = S_DONE;
                        else                              w_state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    // Leave one cycle after the final request has been counted
                    if (!w_remaining) w_state_next = S_DONE;
                end
                S_DONE:  w_state_next = S_DONE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        w_ctrl_issue = 1'b0;
        w_run_issue  = 1'b0;
        w_load       = 1'b0;
        if (!w_abort) begin
            w_ctrl_issue = (r_state == S_CTRL_REQ) && !stall;
            w_run_issue  = (r_state == S_RUN) && !stall && w_remaining;
            w_load       = (r_state == S_CTRL_WAIT) && w_resp_start;
        end
        w_valid_next = w_ctrl_issue || w_run_issue;
        w_mdata_next = r_rd_mdata;
        w_addr_next  = r_rd_addr;
        if (w_ctrl_issue) begin
            w_mdata_next = CTRL_MDATA;
            w_addr_next  = ctrl_addr;
        end else if (w_run_issue) begin
            w_mdata_next = RUN_MDATA;
            w_addr_next  = w_line_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
            r_rd_mdata <= '0;
            r_rd_addr  <= '0;
            r_rd_done  <= 1'b0;
        end else begin
            r_rd_valid <= w_valid_next;
            r_rd_mdata <= w_mdata_next;
            r_rd_addr  <= w_addr_next;
            r_rd_done  <= (w_state_next == S_DONE);
        end
    end

    rd_line_counter #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_line_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (w_load),
        .load_base (ctrl_resp_rd_addr),
        .load_num  (ctrl_resp_num_cls),
        .inc       (w_run_issue),
        .issued    (rd_issued),
        .line_addr (w_line_addr),
        .remaining (w_remaining)
    );

    assign rd_valid = r_rd_valid;
    assign rd_mdata = r_rd_mdata;
    assign rd_addr  = r_rd_addr;
    assign rd_done  = r_rd_done;

`ifdef READ_ENGINE_STATS_EN
    // Counts cycles a pending request was held back; restarts with each run
    logic [CNT_W-1:0] r_stall_cycles;
    logic             w_stall_hit;
    logic             w_stats_clear;

    assign w_stall_hit   = stall && ((r_state == S_CTRL_REQ) ||
                                     ((r_state == S_RUN) && w_remaining));
    assign w_stats_clear = w_load && (w_state_next == S_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if (w_stats_clear) begin
            r_stall_cycles <= '0;
        end else if (w_stall_hit && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_read_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_read_engine
//  Description : Self-checking bench for read_engine. A cycle-level reference
//                model expressed as run phases and plain address arithmetic
//                predicts every output each cycle; directed scenarios pin the
//                model against hand-computed request lists, followed by a
//                randomized stress phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_read_engine;

`ifdef READ_ENGINE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [1:0]  afu_state;
    logic [41:0] ctrl_addr;
    logic        ctrl_resp_valid;
    logic [31:0] ctrl_resp_code;
    logic [41:0] ctrl_resp_rd_addr;
    logic [31:0] ctrl_resp_num_cls;
    logic        rd_valid;
    logic [15:0] rd_mdata;
    logic [41:0] rd_addr;
    logic        rd_done;
    logic [31:0] rd_issued;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    read_engine dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .stall             (stall),
        .afu_state         (afu_state),
        .ctrl_addr         (ctrl_addr),
        .ctrl_resp_valid   (ctrl_resp_valid),
        .ctrl_resp_code    (ctrl_resp_code),
        .ctrl_resp_rd_addr (ctrl_resp_rd_addr),
        .ctrl_resp_num_cls (ctrl_resp_num_cls),
        .rd_valid          (rd_valid),
        .rd_mdata          (rd_mdata),
        .rd_addr           (rd_addr),
        .rd_done           (rd_done),
        .rd_issued         (rd_issued),
        .stall_cycles      (stall_cycles)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 fetch control, 2 await response,
    // 3 streaming data, 4 finished
    int          m_phase;
    logic [41:0] m_base;
    logic [31:0] m_num;
    logic [31:0] m_cnt;
    logic        m_valid;
    logic [41:0] m_addr;
    logic [15:0] m_mdata;
    logic        m_done;
    logic [31:0] m_stall;

    logic [41:0] q_addr[$];
    logic [15:0] q_mdata[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_base = '0; m_num = '0; m_cnt = '0;
        m_valid = 1'b0; m_addr = '0; m_mdata = '0; m_done = 1'b0; m_stall = '0;
    endtask

    // Predict the outputs after the coming clock edge from the current inputs
    task automatic model_next();
        int np;
        bit v;
        bit hit;
        if (!reset_n) begin
            model_reset();
            return;
        end
        np  = m_phase;
        v   = 1'b0;
        hit = stall && (m_phase == 1 || (m_phase == 3 && m_cnt < m_num));
        if (STATS && hit && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (afu_state == 2'd0) begin
            np = 0;
        end else begin
            case (m_phase)
                0: if (afu_state == 2'd1) np = 1;
                1: if (!stall) begin
                    v = 1'b1; m_addr = ctrl_addr; m_mdata = 16'h0001; np = 2;
                end
                2: if (ctrl_resp_valid) begin
                    if (ctrl_resp_code == 32'h1) begin
                        m_base = ctrl_resp_rd_addr;
                        m_num  = ctrl_resp_num_cls;
                        m_cnt  = 0;
                        if (m_num == 0) np = 4;
                        else begin np = 3; m_stall = 0; end
                    end else begin
                        np = 1;
                    end
                end
                3: if (m_cnt == m_num) np = 4;
                   else if (!stall) begin
                    v = 1'b1; m_addr = m_base + 42'(m_cnt); m_mdata = 16'h0002; m_cnt = m_cnt + 1;
                end
                default: ;
            endcase
        end
        m_valid = v;
        m_done  = (np == 4);
        m_phase = np;
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        @(negedge clk);
        chk("rd_valid",     64'(rd_valid),     64'(m_valid));
        chk("rd_done",      64'(rd_done),      64'(m_done));
        chk("rd_issued",    64'(rd_issued),    64'(m_cnt));
        chk("rd_addr",      64'(rd_addr),      64'(m_addr));
        chk("rd_mdata",     64'(rd_mdata),     64'(m_mdata));
        chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        if (rd_valid === 1'b1) begin
            q_addr.push_back(rd_addr);
            q_mdata.push_back(rd_mdata);
        end
    endtask

    task automatic run_until(input int phase, input int budget);
        int n = 0;
        while (m_phase != phase && n < budget) begin
            step();
            n++;
        end
        if (m_phase != phase) chk("phase_timeout", 64'(m_phase), 64'(phase));
    endtask

    task automatic respond(input logic [31:0] code, input logic [41:0] base, input logic [31:0] num);
        ctrl_resp_valid = 1'b1; ctrl_resp_code = code;
        ctrl_resp_rd_addr = base; ctrl_resp_num_cls = num;
        step();
        ctrl_resp_valid = 1'b0;
    endtask

    task automatic start_fetch(input logic [41:0] addr);
        afu_state = 2'd0; step();
        q_addr.delete(); q_mdata.delete();
        afu_state = 2'd1; ctrl_addr = addr;
        run_until(2, 10);
    endtask

    initial begin
        logic [63:0] r64;
        bit          prev_v;
        reset_n = 1'b0; stall = 1'b0; afu_state = 2'd0; ctrl_addr = '0;
        ctrl_resp_valid = 1'b0; ctrl_resp_code = '0; ctrl_resp_rd_addr = '0; ctrl_resp_num_cls = '0;
        model_reset();
        @(negedge clk);
        chk("reset_valid", 64'(rd_valid), 64'd0);
        chk("reset_addr",  64'(rd_addr),  64'd0);
        chk("reset_mdata", 64'(rd_mdata), 64'd0);
        chk("reset_done",  64'(rd_done),  64'd0);
        chk("reset_issued", 64'(rd_issued), 64'd0);
        chk("reset_stalls", 64'(stall_cycles), 64'd0);
        reset_n = 1'b1;

        // Control fetch and plain 4-line run; afu_state=RUN before start is ignored
        start_fetch(42'h100);
        afu_state = 2'd2;
        repeat (3) step();
        afu_state = 2'd1;
        respond(32'h1, 42'h2000, 32'd4);
        run_until(4, 20);
        step();
        chk("run_req_count", 64'(q_addr.size()), 64'd5);
        if (q_addr.size() == 5) begin
            chk("ctrl_addr",  64'(q_addr[0]),  64'h100);
            chk("ctrl_mdata", 64'(q_mdata[0]), 64'h1);
            for (int i = 1; i < 5; i++) begin
                chk("run_addr",  64'(q_addr[i]),  64'h2000 + 64'(i - 1));
                chk("run_mdata", 64'(q_mdata[i]), 64'h2);
            end
        end
        chk("run_done",   64'(rd_done),   64'd1);
        chk("run_issued", 64'(rd_issued), 64'd4);

        // Abort from the finished state
        afu_state = 2'd0; step();
        chk("abort_done",   64'(rd_done),   64'd0);
        chk("abort_issued", 64'(rd_issued), 64'd4);

        // Stalled run: three stall cycles mid-stream
        start_fetch(42'h140);
        q_addr.delete(); q_mdata.delete();
        respond(32'h1, 42'h3000, 32'd4);
        step();
        stall = 1'b1; repeat (3) step();
        stall = 1'b0;
        run_until(4, 20);
        chk("stall_req_count", 64'(q_addr.size()), 64'd4);
        for (int i = 0; i < q_addr.size(); i++)
            chk("stall_addr", 64'(q_addr[i]), 64'h3000 + 64'(i));
        chk("stall_cycles_lit", 64'(stall_cycles), STATS ? 64'd3 : 64'd0);

        // Re-poll on a non-start code, then an empty run
        start_fetch(42'h180);
        respond(32'h0, 42'h5000, 32'd2);
        run_until(2, 10);
        respond(32'h1, 42'h5000, 32'd0);
        repeat (2) step();
        chk("repoll_req_count", 64'(q_addr.size()), 64'd2);
        if (q_addr.size() == 2) begin
            chk("repoll_addr", 64'(q_addr[1]), 64'h180);
            chk("repoll_mdata", 64'(q_mdata[1]), 64'h1);
        end
        chk("empty_done",   64'(rd_done),   64'd1);
        chk("empty_issued", 64'(rd_issued), 64'd0);

        // Address wrap at 2^42
        start_fetch(42'h1C0);
        q_addr.delete(); q_mdata.delete();
        respond(32'h1, 42'h3FF_FFFF_FFFE, 32'd3);
        run_until(4, 20);
        chk("wrap_req_count", 64'(q_addr.size()), 64'd3);
        if (q_addr.size() == 3) begin
            chk("wrap_addr0", 64'(q_addr[0]), 64'h3FF_FFFF_FFFE);
            chk("wrap_addr1", 64'(q_addr[1]), 64'h3FF_FFFF_FFFF);
            chk("wrap_addr2", 64'(q_addr[2]), 64'h0);
        end

        // Asynchronous reset in the middle of a run
        start_fetch(42'h200);
        respond(32'h1, 42'h8000, 32'd20);
        repeat (4) step();
        #2 reset_n = 1'b0;
        #1;
        chk("areset_valid",  64'(rd_valid),  64'd0);
        chk("areset_addr",   64'(rd_addr),   64'd0);
        chk("areset_issued", 64'(rd_issued), 64'd0);
        chk("areset_done",   64'(rd_done),   64'd0);
        model_reset();
        @(negedge clk);
        step();
        reset_n = 1'b1;
        q_addr.delete(); q_mdata.delete();
        run_until(2, 10);
        chk("refetch_count", 64'(q_addr.size()), 64'd1);
        if (q_addr.size() == 1) chk("refetch_mdata", 64'(q_mdata[0]), 64'h1);

        // Randomized stress against the model
        prev_v = 1'b0;
        for (int c = 0; c < 600; c++) begin
            stall = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 3) afu_state = 2'($urandom_range(0, 3));
            else if (afu_state == 2'd0 && $urandom_range(0, 99) < 30) afu_state = 2'd1;
            if ($urandom_range(0, 99) < 10) ctrl_addr = 42'($urandom);
            ctrl_resp_valid = !prev_v && ($urandom_range(0, 5) == 0);
            prev_v = ctrl_resp_valid;
            case ($urandom_range(0, 3))
                0:       ctrl_resp_code = 32'h0;
                1:       ctrl_resp_code = 32'h7;
                default: ctrl_resp_code = 32'h1;
            endcase
            r64 = {$urandom, $urandom};
            ctrl_resp_rd_addr = ($urandom_range(0, 1) == 0) ? r64[41:0]
                              : 42'h3FF_FFFF_FFFC + 42'($urandom_range(0, 3));
            ctrl_resp_num_cls = 32'($urandom_range(0, 6));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
